// File: rtl/cache_ram_port.sv
// cache_ram_port: one-word-per-request req/ack bridge from cache_control to main RAM.
// Optional CACHE_RAM_TIMEOUT_EN adds a REQ wait counter, abort path and sticky err_out.
`default_nettype none

module cache_ram_port #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int OFS_W   = 5
`ifdef CACHE_RAM_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ram_en_in,
  input  logic              ram_write_in,
  input  logic [1:0]        ram_addr_sel_in,
  input  logic [2:0]        word_sel_in,
  input  logic [ADDR_W-1:0] ic_addr_in,
  input  logic [ADDR_W-1:0] dc_addr_in,
  input  logic [ADDR_W-1:0] dc_wb_addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic [DATA_W-1:0] rdata_out,
  output logic              word_done_out,
  output logic              busy_out,
  output logic              mem_req_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_wdata_out,
  input  logic              mem_ack_in,
  input  logic [DATA_W-1:0] mem_rdata_in,
  output logic              err_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] launch_addr;
  logic              launch;
  logic              timeout_hit;

  always_comb begin
    sel_addr = ic_addr_in;
    case (ram_addr_sel_in)
      2'b01:   sel_addr = dc_addr_in;
      2'b11:   sel_addr = dc_wb_addr_in;
      default: sel_addr = ic_addr_in;
    endcase
  end

  assign launch_addr = {sel_addr[ADDR_W-1:OFS_W], word_sel_in[OFS_W-3:0], 2'b00};
  // Selector 10 is reserved and never starts a transfer.
  assign launch      = (state == IDLE) && ram_en_in && (ram_addr_sel_in != 2'b10);

`ifdef CACHE_RAM_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign timeout_hit = (state == REQ) && (wait_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
      err_out  <= 1'b0;
    end else begin
      if (launch)
        wait_cnt <= 8'd0;
      else if (state == REQ)
        wait_cnt <= wait_cnt + 8'd1;
      // An ack arriving on the final wait cycle still wins over the abort.
      if (timeout_hit && !mem_ack_in)
        err_out <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_out     = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = REQ;
      REQ:     if (mem_ack_in || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      mem_we_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
      rdata_out     <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        mem_we_out    <= ram_write_in;
        mem_addr_out  <= launch_addr;
        mem_wdata_out <= wdata_in;
      end
      if ((state == REQ) && mem_ack_in && !mem_we_out)
        rdata_out <= mem_rdata_in;
    end
  end

  assign mem_req_out   = (state == REQ);
  assign word_done_out = (state == DONE);
  assign busy_out      = launch || (state == REQ);

endmodule

`default_nettype wire

// File: tb/tb_cache_ram_port.sv
// tb_cache_ram_port: directed vector table plus hand sequences for cache_ram_port.
`default_nettype none

module tb_cache_ram_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ram_en = 1'b0;
  logic        ram_write = 1'b0;
  logic [1:0]  ram_addr_sel = 2'b00;
  logic [2:0]  word_sel = 3'd0;
  logic [31:0] ic_addr = '0, dc_addr = '0, dc_wb_addr = '0, wdata = '0;
  logic [31:0] rdata_out, mem_addr, mem_wdata;
  logic        word_done, busy, mem_req, mem_we, err;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'hBAD0_BAD0;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_rdata = '0;

  always #5 clk = ~clk;

  cache_ram_port #(
    .ADDR_W(32), .DATA_W(32), .OFS_W(5)
`ifdef CACHE_RAM_TIMEOUT_EN
    , .TIMEOUT(8)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ram_en_in(ram_en), .ram_write_in(ram_write), .ram_addr_sel_in(ram_addr_sel),
    .word_sel_in(word_sel), .ic_addr_in(ic_addr), .dc_addr_in(dc_addr),
    .dc_wb_addr_in(dc_wb_addr), .wdata_in(wdata),
    .rdata_out(rdata_out), .word_done_out(word_done), .busy_out(busy),
    .mem_req_out(mem_req), .mem_we_out(mem_we), .mem_addr_out(mem_addr),
    .mem_wdata_out(mem_wdata), .mem_ack_in(mem_ack), .mem_rdata_in(mem_rdata),
    .err_out(err)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  ws;
    logic        we;
    logic [31:0] ic, dc, wb, wd;
    int          delay;
    logic [31:0] rd;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    ram_addr_sel = v.sel; word_sel = v.ws; ram_write = v.we;
    ic_addr = v.ic; dc_addr = v.dc; dc_wb_addr = v.wb; wdata = v.wd;
    ram_en = 1'b1;
    #1;
    chk($sformatf("v%0d busy_at_launch", idx), {31'b0, busy}, 32'd1);
    chk($sformatf("v%0d req_before_launch", idx), {31'b0, mem_req}, 32'd0);
    @(negedge clk);
    ram_en = 1'b0;
    for (int k = 1; k <= v.delay; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 2) begin
        // Inputs change mid-REQ; the latched transfer must not notice.
        ic_addr = ~v.ic; dc_addr = ~v.dc; dc_wb_addr = ~v.wb; wdata = ~v.wd;
        word_sel = v.ws ^ 3'd7; ram_write = ~v.we; ram_addr_sel = 2'b00;
        #1;
      end
      chk($sformatf("v%0d req c%0d", idx, k), {31'b0, mem_req}, 32'd1);
      chk($sformatf("v%0d addr c%0d", idx, k), mem_addr, v.exp_addr);
      chk($sformatf("v%0d we c%0d", idx, k), {31'b0, mem_we}, {31'b0, v.we});
      chk($sformatf("v%0d wdata c%0d", idx, k), mem_wdata, v.wd);
      chk($sformatf("v%0d done_early c%0d", idx, k), {31'b0, word_done}, 32'd0);
      if (k == v.delay) begin
        mem_ack = 1'b1; mem_rdata = v.rd;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'hBAD0_BAD0;
    if (!v.we) exp_rdata = v.rd;
    chk($sformatf("v%0d word_done", idx), {31'b0, word_done}, 32'd1);
    chk($sformatf("v%0d req_after_ack", idx), {31'b0, mem_req}, 32'd0);
    chk($sformatf("v%0d busy_in_done", idx), {31'b0, busy}, 32'd0);
    chk($sformatf("v%0d rdata_out", idx), rdata_out, exp_rdata);
    @(negedge clk);
    chk($sformatf("v%0d done_one_cycle", idx), {31'b0, word_done}, 32'd0);
    chk($sformatf("v%0d idle_req", idx), {31'b0, mem_req}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{sel:2'b00, ws:3'd1, we:1'b0, ic:32'h1000_0040, dc:32'h5555_5500,
                wb:32'h6666_6600, wd:32'h0, delay:1, rd:32'hA5A5_0001, exp_addr:32'h1000_0044};
    vecs[1] = '{sel:2'b11, ws:3'd0, we:1'b1, ic:32'h7777_7700, dc:32'h5555_5500,
                wb:32'h2000_0020, wd:32'hCAFE_F00D, delay:4, rd:32'h0BAD_0001, exp_addr:32'h2000_0020};
    vecs[2] = '{sel:2'b01, ws:3'd7, we:1'b0, ic:32'h7777_7700, dc:32'h3000_105F,
                wb:32'h6666_6600, wd:32'h1, delay:3, rd:32'h1234_5678, exp_addr:32'h3000_105C};
    vecs[3] = '{sel:2'b00, ws:3'd3, we:1'b0, ic:32'hFFFF_FFE4, dc:32'h5555_5500,
                wb:32'h6666_6600, wd:32'h2, delay:2, rd:32'hDEAD_BEEF, exp_addr:32'hFFFF_FFEC};
    vecs[4] = '{sel:2'b01, ws:3'd2, we:1'b1, ic:32'h7777_7700, dc:32'h0000_0000,
                wb:32'h6666_6600, wd:32'h1111_2222, delay:1, rd:32'h0BAD_0002, exp_addr:32'h0000_0008};

    repeat (2) @(negedge clk);
    chk("rst req", {31'b0, mem_req}, 32'd0);
    chk("rst done", {31'b0, word_done}, 32'd0);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst rdata", rdata_out, 32'd0);
    chk("rst addr", mem_addr, 32'd0);
    chk("rst err", {31'b0, err}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Ack while idle must be ignored.
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'hBAD0_BAD0;
    chk("idle_ack rdata", rdata_out, exp_rdata);
    chk("idle_ack done", {31'b0, word_done}, 32'd0);

    // Reserved selector never launches.
    ram_addr_sel = 2'b10; ram_write = 1'b0; ram_en = 1'b1;
    #1;
    chk("sel10 busy", {31'b0, busy}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("sel10 req c%0d", k), {31'b0, mem_req}, 32'd0);
      chk($sformatf("sel10 done c%0d", k), {31'b0, word_done}, 32'd0);
    end
    ram_en = 1'b0;

    // Reset in the middle of a request.
    @(negedge clk);
    ram_addr_sel = 2'b01; dc_addr = 32'h4444_4400; word_sel = 3'd0; ram_en = 1'b1;
    @(negedge clk);
    ram_en = 1'b0;
    chk("midrst req_before", {31'b0, mem_req}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst req_async", {31'b0, mem_req}, 32'd0);
    exp_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      chk($sformatf("midrst done c%0d", k), {31'b0, word_done}, 32'd0);
      chk($sformatf("midrst req c%0d", k), {31'b0, mem_req}, 32'd0);
    end
    chk("midrst rdata", rdata_out, exp_rdata);

`ifdef CACHE_RAM_TIMEOUT_EN
    begin
      int n;
      @(negedge clk);
      ram_addr_sel = 2'b00; ic_addr = 32'h4000_0000; word_sel = 3'd0; ram_write = 1'b0;
      ram_en = 1'b1;
      @(negedge clk);
      ram_en = 1'b0;
      n = 0;
      while (mem_req && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("to req_cycles", n, 32'd8);
      chk("to done", {31'b0, word_done}, 32'd1);
      chk("to err", {31'b0, err}, 32'd1);
      chk("to rdata", rdata_out, exp_rdata);
      @(negedge clk);
      chk("to done_once", {31'b0, word_done}, 32'd0);
      chk("to err_sticky", {31'b0, err}, 32'd1);
      run_vec(9, vecs[0]);
      chk("to err_after_xfer", {31'b0, err}, 32'd1);
    end
`else
    begin
      int n;
      @(negedge clk);
      ram_addr_sel = 2'b00; ic_addr = 32'h4000_0000; word_sel = 3'd0; ram_write = 1'b0;
      ram_en = 1'b1;
      @(negedge clk);
      ram_en = 1'b0;
      n = 0;
      while (mem_req && n < 100) begin
        n++;
        @(negedge clk);
      end
      chk("wait req_held", n, 32'd100);
      chk("wait err_zero", {31'b0, err}, 32'd0);
      chk("wait no_done", {31'b0, word_done}, 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'h5A5A_A5A5;
      @(negedge clk);
      mem_ack = 1'b0;
      exp_rdata = 32'h5A5A_A5A5;
      chk("wait done", {31'b0, word_done}, 32'd1);
      chk("wait rdata", rdata_out, exp_rdata);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
